uart_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares one `uart_tx` serializer among `NUM_REQ` byte producers. It accepts bytes through per-requester valid/ready handshakes and holds the granted byte stable on the serializer's data input. It issues a one-cycle `start_trigger` and counts `baud_tick` until the serializer has returned to idle. It sits between the application-side producers and `uart_tx`, sharing `clk` and `baud_tick` with it.

---
 rtl/uart_tx_sched.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Round-robin transmit scheduler sharing one uart_tx serializer
//                among NUM_REQ byte producers. Accepts one byte per frame via
//                per-requester valid/ready, holds it on tx_byte, pulses
//                start_trigger once and counts baud ticks until the serializer
//                is idle again.
//  Ports       : clk           - system clock, rising edge
//                rst_n         - synchronous active-low reset
//                baud_tick     - one-cycle baud strobe shared with uart_tx
//                req_valid     - per-requester byte available
//                req_data      - byte i at [8*i+7:8*i]
//                req_ready     - one-hot, one-cycle accept pulse
//                start_trigger - one-cycle start pulse to uart_tx (registered)
//                tx_byte       - byte to uart_tx, held until next grant
//                busy          - scheduler not idle
//                grant_id      - index of the last granted requester
//                frame_done    - pulse on the frame's last counted baud tick
//  Config      : `define UART_TX_SCHED_PRIO_EN makes requester 0 strict high
//                priority; requesters 1..NUM_REQ-1 stay round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       baud_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       start_trigger,
  output logic [7:0]                 tx_byte,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_cnt_w = $clog2(FRAME_TICKS + 1);

  typedef logic [c_id_w-1:0]  id_t;
  typedef logic [c_cnt_w-1:0] cnt_t;

  localparam cnt_t c_last_cnt = cnt_t'(FRAME_TICKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;

  logic [1:0]   r_state;
  cnt_t         r_tick_cnt;
  id_t          r_last;
  id_t          r_grant_id;
  logic [7:0]   r_tx_byte;
  logic         r_start;

  logic         w_found;
  id_t          w_winner;
  id_t          w_idx;
  logic         w_grant;
  logic         w_last_tick;
  logic [7:0]   w_byte;
  logic [NUM_REQ-1:0] w_ready;

  // --------------------------------------------------------------------------
  // Arbiter: scan upward from the requester after the previous grant, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
`ifdef UART_TX_SCHED_PRIO_EN
    // Requester 0 preempts; the rotation only covers 1..NUM_REQ-1, so r_last
    // never holds 0 and the offset arithmetic below stays non-negative.
    if (req_valid[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        w_idx = id_t'(1 + ((int'(r_last) - 1 + k) % (NUM_REQ - 1)));
        if (!w_found && req_valid[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = id_t'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`endif
  end

  // Winner's byte, selected with constant slices only.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == id_t'(i)) begin
        w_byte = req_data[8*i +: 8];
      end
    end
  end

  // Gated by rst_n so a producer never sees an accept in a cycle whose edge
  // is a reset edge (the byte would otherwise be lost).
  assign w_grant     = rst_n && (r_state == S_IDLE) && w_found;
  assign w_last_tick = (r_state == S_FRAME) && baud_tick && (r_tick_cnt == c_last_cnt);

  always_comb begin
    w_ready           = '0;
    w_ready[w_winner] = w_grant;
  end

  // --------------------------------------------------------------------------
  // Frame sequencing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_last     <= id_t'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx_byte  <= 8'h00;
      r_start    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_tx_byte  <= w_byte;
            r_grant_id <= w_winner;
`ifdef UART_TX_SCHED_PRIO_EN
            if (w_winner != '0) begin
              r_last <= w_winner;
            end
`else
            r_last <= w_winner;
`endif
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          // The serializer is still idle here, so a coincident baud tick is
          // deliberately ignored.
          r_tick_cnt <= '0;
          r_state    <= S_FRAME;
        end
        S_FRAME: begin
          if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (w_last_tick) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = w_ready;
  assign start_trigger = r_start;
  assign tx_byte       = r_tx_byte;
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_grant_id;
  assign frame_done    = rst_n && w_last_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Self-checking bench for uart_tx_sched with a frame-level
//                reference model and directed plus randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int FT = 11;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           baud_tick;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           start_trigger;
  logic [7:0]     tx_byte;
  logic           busy;
  logic [1:0]     grant_id;
  logic           frame_done;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .FRAME_TICKS(FT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .start_trigger(start_trigger),
    .tx_byte      (tx_byte),
    .busy         (busy),
    .grant_id     (grant_id),
    .frame_done   (frame_done)
  );

  // Reference model: a frame is "in flight" from the start cycle until the
  // FT-th baud tick counted after it.
  bit         m_frame, m_start;
  int         m_ticks, m_last, m_gid;
  logic [7:0] m_tx;

  int  grant_log[$];
  int  n_vec = 0, n_fail = 0;
  int  cyc_n = 0;
  bit  tick_rand = 0, tick_on_start = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int idx;
`ifdef UART_TX_SCHED_PRIO_EN
    if (req_valid[0]) return 0;
    for (int k = 1; k < N; k++) begin
      idx = 1 + ((m_last - 1 + k) % (N - 1));
      if (req_valid[idx]) return idx;
    end
`else
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (req_valid[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_frame = 0; m_start = 0; m_ticks = 0; m_last = N - 1; m_gid = 0; m_tx = 8'h00;
  endtask

  // One clock: check at negedge, advance model at posedge, drive next inputs.
  task automatic cyc();
    int         w;
    logic [N-1:0] exp_rdy;
    bit         exp_fd;
    @(negedge clk);
    w       = (!m_frame && rst_n) ? pick() : -1;
    exp_rdy = (w >= 0) ? N'(1 << w) : '0;
    exp_fd  = rst_n && m_frame && !m_start && baud_tick && (m_ticks == FT - 1);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("start_trigger", 32'(start_trigger), 32'(m_start));
    chk("busy", 32'(busy), 32'(m_frame));
    chk("tx_byte", 32'(tx_byte), 32'(m_tx));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) grant_log.push_back(i);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      w = -1;
    end else if (w >= 0) begin
      m_tx    = req_data[8*w +: 8];
      m_gid   = w;
`ifdef UART_TX_SCHED_PRIO_EN
      if (w != 0) m_last = w;
`else
      m_last  = w;
`endif
      m_frame = 1; m_start = 1;
    end else if (m_start) begin
      m_start = 0; m_ticks = 0;
    end else if (m_frame && baud_tick) begin
      m_ticks++;
      if (m_ticks == FT) m_frame = 0;
    end
    #1;
    cyc_n++;
    if (w >= 0) req_data[8*w +: 8] = 8'($urandom);
    baud_tick = tick_rand ? ($urandom_range(0, 3) == 0) : ((cyc_n % 16) == 0);
    if (tick_on_start && m_start) baud_tick = 1'b1;
  endtask

  task automatic wait_grant(input int max_cyc);
    bit got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      cyc();
      got = (start_trigger === 1'b1);
    end
    chk("grant_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      cyc();
      got = (busy === 1'b0);
    end
    chk("idle_timeout", 32'(got), 32'd1);
  endtask

  task automatic check_log(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, 32'(grant_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      chk({tag, "_id"}, 32'(grant_log[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_q[$];
    int guard;
    rst_n = 1'b0; req_valid = '0; req_data = '0; baud_tick = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset values
    do_reset(3);

    // Single request from requester 1
    grant_log.delete();
    req_data[15:8] = 8'hA5;
    req_valid = 4'b0010;
    wait_grant(20);
    req_valid = '0;
    chk("single_tx", 32'(tx_byte), 32'h0000_00A5);
    wait_idle(300);
    chk("single_hold", 32'(tx_byte), 32'h0000_00A5);
    exp_q = '{1};
    check_log("single", exp_q);

    // All four requesting continuously after reset
    do_reset(1);
    grant_log.delete();
    req_data = {$urandom, $urandom} ;
    req_valid = 4'b1111;
    guard = 0;
    while (grant_log.size() < 5 && guard < 1500) begin cyc(); guard++; end
    req_valid = '0;
    wait_idle(300);
    exp_q = '{0, 1, 2, 3, 0};
    check_log("rr4", exp_q);

    // Baud tick coincident with start_trigger must not be counted
    grant_log.delete();
    tick_on_start = 1;
    req_valid = 4'b0001;
    wait_grant(20);
    req_valid = '0;
    wait_idle(300);
    tick_on_start = 0;
    exp_q = '{0};
    check_log("tick_start", exp_q);

    // Requester 2 withdraws before grant while requester 3 is valid
    grant_log.delete();
    req_valid = 4'b0001;
    wait_grant(20);
    req_valid = 4'b0100;
    guard = 0;
    while (m_ticks < 8 && guard < 300) begin cyc(); guard++; end
    req_valid = 4'b1000;
    wait_idle(300);
    wait_grant(20);
    req_valid = '0;
    wait_idle(300);
    exp_q = '{0, 3};
    check_log("withdraw", exp_q);

    // Reset mid-frame at tick 5; next grant goes to requester 0
    grant_log.delete();
    req_valid = 4'b0110;
    wait_grant(20);
    guard = 0;
    while (m_ticks < 5 && guard < 300) begin cyc(); guard++; end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    wait_grant(20);
    req_valid = '0;
    wait_idle(300);
    exp_q = '{1, 0};
    check_log("midreset", exp_q);

`ifdef UART_TX_SCHED_PRIO_EN
    // Strict priority for requester 0
    do_reset(1);
    grant_log.delete();
    req_valid = 4'b0101;
    guard = 0;
    while (grant_log.size() < 3 && guard < 1000) begin cyc(); guard++; end
    req_valid = 4'b0100;
    wait_idle(300);
    wait_grant(20);
    req_valid = '0;
    wait_idle(300);
    exp_q = '{0, 0, 0, 2};
    check_log("prio", exp_q);
`endif

    // Randomized traffic, random baud ticks, occasional resets
    tick_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req_valid = N'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1;
    req_valid = '0;
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
